// File: rtl/fea_pkg.sv
// Shared definitions for the global input-feature stream: vector geometry, frame size and the
// receive FSM state type. Used by the feature loader, this receiver and the conv1 input stage.
package fea_pkg;

  localparam int unsigned FEA_DATA_W     = 400;  // 25 elements x 16 bit
  localparam int unsigned FEA_BANK_DEPTH = 75;   // 25 columns x 3 channels
  localparam int unsigned FEA_ADDR_W     = 7;    // ceil(log2(FEA_BANK_DEPTH))
  localparam int unsigned FEA_FRAME_VECS = 450;  // 150 rows x 3 channels
  localparam int unsigned FEA_CNT_W      = $clog2(FEA_FRAME_VECS + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FILL  = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } fea_state_e;

endpackage

// File: rtl/fea_pp_ram.sv
// Ping-pong feature storage: simple dual-port RAM holding two banks of Depth vectors each.
// Bank b, pointer p maps to linear address b*Depth + p. Registered read, one cycle latency.
// Ports:
//   clk_i, rst_i          clock, synchronous active-high reset (clears the read register only)
//   we_i, wr_bank_i,
//   wr_ptr_i, wdata_i     write port
//   re_i, rd_bank_i,
//   rd_ptr_i              read port request
//   rdata_o               read data, updated the cycle after re_i
module fea_pp_ram #(
  parameter int unsigned DataW = 400,
  parameter int unsigned Depth = 75,
  parameter int unsigned AddrW = 7
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             we_i,
  input  logic             wr_bank_i,
  input  logic [AddrW-1:0] wr_ptr_i,
  input  logic [DataW-1:0] wdata_i,
  input  logic             re_i,
  input  logic             rd_bank_i,
  input  logic [AddrW-1:0] rd_ptr_i,
  output logic [DataW-1:0] rdata_o
);

  localparam int unsigned RamDepth = 2 * Depth;
  localparam int unsigned RamAW    = $clog2(RamDepth);

  logic [DataW-1:0] mem_q [RamDepth];
  logic [DataW-1:0] rdata_q;
  logic [RamAW-1:0] waddr;
  logic [RamAW-1:0] raddr;

  always_comb begin
    waddr = RamAW'(wr_ptr_i) + (wr_bank_i ? RamAW'(Depth) : RamAW'(0));
    raddr = RamAW'(rd_ptr_i) + (rd_bank_i ? RamAW'(Depth) : RamAW'(0));
  end

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr] <= wdata_i;
    end
  end

  // Out-of-range read pointers return whatever the array yields; the consumer owns that bug.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rdata_q <= '0;
    end else if (re_i) begin
      rdata_q <= mem_q[raddr];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/fea_pingpong_rx.sv
// Receive end of the global input-feature stream. Vectors are written alternately into two
// banks; a full bank is exposed to the conv PE array for random-access reads until released.
// halt back-pressures the loader whenever the bank about to be written is still full.
// Ports:
//   clk, rst                     clock, synchronous active-high reset
//   start                        arm a new frame (only honoured in IDLE or DONE)
//   data_v, in_fea, halt         input vector stream with back-pressure
//   rd_bank_v, rd_bank_id        full-bank availability and which bank reads target
//   rd_en, rd_addr               read request
//   rd_data, rd_data_v           read response, one cycle after rd_en
//   rd_release                   consumer done with the current read bank
//   frame_done                   pulse once the final bank of a frame has been released
module fea_pingpong_rx
  import fea_pkg::*;
#(
  parameter int unsigned DATA_W     = FEA_DATA_W,
  parameter int unsigned BANK_DEPTH = FEA_BANK_DEPTH,
  parameter int unsigned ADDR_W     = FEA_ADDR_W,
  parameter int unsigned FRAME_VECS = FEA_FRAME_VECS
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              data_v,
  input  logic [DATA_W-1:0] in_fea,
  output logic              halt,
  output logic              rd_bank_v,
  output logic              rd_bank_id,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_data_v,
  input  logic              rd_release,
  output logic              frame_done
);

  localparam int unsigned CntW = $clog2(FRAME_VECS + 1);
  localparam logic [ADDR_W-1:0] LastPtr    = ADDR_W'(BANK_DEPTH - 1);
  localparam logic [CntW-1:0]   FrameVecsC = CntW'(FRAME_VECS);

  fea_state_e        state_q, state_d;
  logic              wr_bank_q, wr_bank_d;
  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [CntW-1:0]   vec_cnt_q, vec_cnt_d;
  logic [1:0]        bank_full_q, bank_full_d;
  logic              rd_bank_q, rd_bank_d;
  logic              rd_data_v_q;

  logic accept;
  logic release_ok;
  logic rd_fire;
  logic arm;

  // halt and rd_bank_v come from registers only, so there is no comb path from data_v.
  assign halt       = bank_full_q[wr_bank_q];
  assign rd_bank_v  = bank_full_q[rd_bank_q];
  assign rd_bank_id = rd_bank_q;
  assign rd_data_v  = rd_data_v_q;

  assign accept     = data_v & ~halt & (state_q == FILL);
  assign release_ok = rd_release & rd_bank_v;
  assign rd_fire    = rd_en & rd_bank_v;
  assign arm        = start & ((state_q == IDLE) | (state_q == DONE));

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      wr_bank_q   <= 1'b0;
      wr_ptr_q    <= '0;
      vec_cnt_q   <= '0;
      bank_full_q <= 2'b00;
      rd_bank_q   <= 1'b0;
      rd_data_v_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      wr_bank_q   <= wr_bank_d;
      wr_ptr_q    <= wr_ptr_d;
      vec_cnt_q   <= vec_cnt_d;
      bank_full_q <= bank_full_d;
      rd_bank_q   <= rd_bank_d;
      rd_data_v_q <= rd_fire;
    end
  end

  // Pointer, counter and bank-flag update. A fill and a release in the same cycle always
  // target different banks, so both updates are applied.
  always_comb begin
    wr_bank_d   = wr_bank_q;
    wr_ptr_d    = wr_ptr_q;
    vec_cnt_d   = vec_cnt_q;
    bank_full_d = bank_full_q;
    rd_bank_d   = rd_bank_q;

    if (arm) begin
      wr_ptr_d  = '0;
      vec_cnt_d = '0;
    end else if (accept) begin
      vec_cnt_d = vec_cnt_q + 1'b1;
      if (wr_ptr_q == LastPtr) begin
        wr_ptr_d               = '0;
        bank_full_d[wr_bank_q] = 1'b1;
        wr_bank_d              = ~wr_bank_q;
      end else begin
        wr_ptr_d = wr_ptr_q + 1'b1;
      end
    end

    if (release_ok) begin
      bank_full_d[rd_bank_q] = 1'b0;
      rd_bank_d              = ~rd_bank_q;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:  if (start) state_d = FILL;
      FILL:  if (accept && (vec_cnt_d == FrameVecsC)) state_d = DRAIN;
      DRAIN: if (bank_full_q == 2'b00) state_d = DONE;
      DONE:  state_d = start ? FILL : IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    frame_done = (state_q == DRAIN) && (bank_full_q == 2'b00);
  end

  fea_pp_ram #(
    .DataW(DATA_W),
    .Depth(BANK_DEPTH),
    .AddrW(ADDR_W)
  ) u_ram (
    .clk_i    (clk),
    .rst_i    (rst),
    .we_i     (accept),
    .wr_bank_i(wr_bank_q),
    .wr_ptr_i (wr_ptr_q),
    .wdata_i  (in_fea),
    .re_i     (rd_fire),
    .rd_bank_i(rd_bank_q),
    .rd_ptr_i (rd_addr),
    .rdata_o  (rd_data)
  );

endmodule

// File: tb/tb_fea_pingpong_rx.sv
module tb_fea_pingpong_rx;

  localparam int DW = 400;
  localparam int BD = 75;
  localparam int AW = 7;
  localparam int FV = 450;

  localparam int S_IDLE  = 0;
  localparam int S_FILL  = 1;
  localparam int S_DRAIN = 2;
  localparam int S_DONE  = 3;

  logic          clk = 1'b0;
  logic          rst, start, data_v, rd_en, rd_release;
  logic [DW-1:0] in_fea;
  logic [AW-1:0] rd_addr;
  logic          halt, rd_bank_v, rd_bank_id, rd_data_v, frame_done;
  logic [DW-1:0] rd_data;

  always #5 clk = ~clk;

  fea_pingpong_rx dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .data_v    (data_v),
    .in_fea    (in_fea),
    .halt      (halt),
    .rd_bank_v (rd_bank_v),
    .rd_bank_id(rd_bank_id),
    .rd_en     (rd_en),
    .rd_addr   (rd_addr),
    .rd_data   (rd_data),
    .rd_data_v (rd_data_v),
    .rd_release(rd_release),
    .frame_done(frame_done)
  );

  int checks = 0;
  int errors = 0;
  int fd_seen = 0;

  // Reference model of the receiver
  bit            m_full [2];
  bit            m_wb, m_rb;
  int            m_ptr, m_cnt, m_state;
  logic [DW-1:0] m_mem [2][BD];
  logic [DW-1:0] exp_q [$];

  function automatic logic [DW-1:0] mkvec(int idx, int salt);
    logic [15:0] e;
    e = 16'(idx ^ salt);
    return {25{e}};
  endfunction

  task automatic clr();
    rst = 1'b0; start = 1'b0; data_v = 1'b0; rd_en = 1'b0; rd_release = 1'b0;
  endtask

  // One clock: compare register-driven outputs, advance the model, score read responses.
  task automatic step();
    bit acc, rel, rd, exp_fd;
    int nstate;
    logic [DW-1:0] exp;
    if (!rst) begin
      exp_fd = (m_state == S_DRAIN) && !m_full[0] && !m_full[1];
      checks++;
      if (halt !== m_full[m_wb]) begin
        errors++;
        $display("FAIL halt: got %b expected %b (cnt %0d)", halt, m_full[m_wb], m_cnt);
      end
      checks++;
      if (rd_bank_v !== m_full[m_rb]) begin
        errors++;
        $display("FAIL rd_bank_v: got %b expected %b", rd_bank_v, m_full[m_rb]);
      end
      checks++;
      if (rd_bank_id !== m_rb) begin
        errors++;
        $display("FAIL rd_bank_id: got %b expected %b", rd_bank_id, m_rb);
      end
      checks++;
      if (frame_done !== exp_fd) begin
        errors++;
        $display("FAIL frame_done: got %b expected %b", frame_done, exp_fd);
      end
      if (frame_done === 1'b1) fd_seen++;
    end
    acc = data_v && !m_full[m_wb] && (m_state == S_FILL);
    rel = rd_release && m_full[m_rb];
    rd  = rd_en && m_full[m_rb] && !rst;
    if (rd) exp_q.push_back(m_mem[m_rb][rd_addr]);
    @(posedge clk);
    #1;
    if (rst) begin
      m_full[0] = 0; m_full[1] = 0; m_wb = 0; m_rb = 0;
      m_ptr = 0; m_cnt = 0; m_state = S_IDLE;
      exp_q.delete();
    end else begin
      nstate = m_state;
      case (m_state)
        S_IDLE:  if (start) nstate = S_FILL;
        S_FILL:  if (acc && (m_cnt + 1 == FV)) nstate = S_DRAIN;
        S_DRAIN: if (!m_full[0] && !m_full[1]) nstate = S_DONE;
        default: nstate = start ? S_FILL : S_IDLE;
      endcase
      if ((m_state == S_IDLE || m_state == S_DONE) && start) begin
        m_ptr = 0; m_cnt = 0;
      end else if (acc) begin
        m_mem[m_wb][m_ptr] = in_fea;
        m_cnt++;
        if (m_ptr == BD - 1) begin
          m_full[m_wb] = 1; m_ptr = 0; m_wb = !m_wb;
        end else begin
          m_ptr++;
        end
      end
      if (rel) begin
        m_full[m_rb] = 0; m_rb = !m_rb;
      end
      m_state = nstate;
    end
    checks++;
    if (rd_data_v !== rd) begin
      errors++;
      $display("FAIL rd_data_v: got %b expected %b", rd_data_v, rd);
    end
    if (rd) begin
      exp = exp_q.pop_front();
      checks++;
      if (rd_data !== exp) begin
        errors++;
        $display("FAIL rd_data: got %h expected %h", rd_data[15:0], exp[15:0]);
      end
    end
  endtask

  task automatic pulse_start();
    clr(); start = 1'b1; step(); start = 1'b0;
  endtask

  task automatic feed(int n, int salt);
    int sent = 0;
    int guard = 0;
    bit will_acc;
    clr();
    while (sent < n && guard < 1000) begin
      data_v = 1'b1;
      in_fea = mkvec(m_cnt, salt);
      will_acc = !m_full[m_wb] && (m_state == S_FILL);
      step();
      if (will_acc) sent++;
      guard++;
    end
    data_v = 1'b0;
    if (sent < n) begin
      errors++;
      $display("FAIL feed_timeout: got %0d vectors expected %0d", sent, n);
    end
  endtask

  // Stream vectors and service banks promptly (two fixed reads, one random read, release).
  task automatic run_frame(int salt, int stop_at);
    int phase = 0;
    bit done = 0;
    for (int guard = 0; guard < 20000 && !done; guard++) begin
      clr();
      if (m_state == S_FILL && m_cnt < stop_at) begin
        data_v = 1'b1;
        in_fea = mkvec(m_cnt, salt);
      end
      if (m_full[m_rb]) begin
        case (phase)
          0: begin rd_en = 1'b1; rd_addr = 7'd0; end
          1: begin rd_en = 1'b1; rd_addr = 7'(BD - 1); end
          2: begin rd_en = 1'b1; rd_addr = 7'($urandom_range(0, BD - 1)); end
          default: rd_release = 1'b1;
        endcase
        phase = (phase + 1) % 4;
      end
      step();
      done = (stop_at < FV) ? (m_cnt >= stop_at) : (m_state == S_IDLE);
    end
    clr();
    if (!done) begin
      errors++;
      $display("FAIL frame_timeout: got cnt %0d expected %0d", m_cnt, stop_at);
    end
  endtask

  task automatic test_reset();
    clr(); rst = 1'b1; step(); rst = 1'b0;
    checks++;
    if ({halt, rd_bank_v, rd_bank_id, rd_data_v, frame_done} !== 5'b0 || rd_data !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got %b/%h expected 0/0",
               {halt, rd_bank_v, rd_bank_id, rd_data_v, frame_done}, rd_data[15:0]);
    end
  endtask

  task automatic test_fill_bank0();
    pulse_start();
    feed(BD, 0);
    checks++;
    if ({rd_bank_v, rd_bank_id, halt} !== 3'b100) begin
      errors++;
      $display("FAIL bank0_full: got %b expected 100", {rd_bank_v, rd_bank_id, halt});
    end
  endtask

  task automatic test_halt();
    feed(BD, 0);
    checks++;
    if (halt !== 1'b1) begin
      errors++;
      $display("FAIL halt_after_150: got %b expected 1", halt);
    end
    // Vector #151 presented while halted, together with a read of bank0 addr 0.
    data_v = 1'b1; in_fea = mkvec(150, 0);
    rd_en = 1'b1; rd_addr = 7'd0;
    step();
    rd_en = 1'b0;
    step();
    checks++;
    if (rd_data !== mkvec(0, 0) || halt !== 1'b1) begin
      errors++;
      $display("FAIL held_vector: got %h/%b expected 0000/1", rd_data[15:0], halt);
    end
  endtask

  task automatic test_release();
    data_v = 1'b1; in_fea = mkvec(150, 0); rd_release = 1'b1;
    step();
    rd_release = 1'b0;
    checks++;
    if (halt !== 1'b0 || rd_bank_id !== 1'b1) begin
      errors++;
      $display("FAIL release_unhalt: got halt %b id %b expected 0 1", halt, rd_bank_id);
    end
    step();
    data_v = 1'b0;
    rd_en = 1'b1; rd_addr = 7'(BD - 1);
    step();
    rd_en = 1'b0;
    checks++;
    if (rd_data_v !== 1'b1 || rd_data !== mkvec(149, 0)) begin
      errors++;
      $display("FAIL read_149: got %b/%h expected 1/0095", rd_data_v, rd_data[15:0]);
    end
    fd_seen = 0;
    run_frame(0, FV);
    checks++;
    if (fd_seen != 1) begin
      errors++;
      $display("FAIL frame_done_count_first: got %0d expected 1", fd_seen);
    end
  endtask

  task automatic test_frame();
    for (int f = 0; f < 2; f++) begin
      fd_seen = 0;
      pulse_start();
      run_frame(0, FV);
      checks++;
      if (fd_seen != 1 || halt !== 1'b0 || rd_bank_v !== 1'b0) begin
        errors++;
        $display("FAIL frame_end: got fd %0d halt %b bv %b expected 1 0 0", fd_seen, halt,
                 rd_bank_v);
      end
    end
  endtask

  task automatic test_reset_mid();
    pulse_start();
    run_frame(16'h5a5a, 100);
    data_v = 1'b1; in_fea = mkvec(100, 16'h5a5a); rst = 1'b1;
    step();
    clr();
    checks++;
    if ({halt, rd_bank_v, rd_bank_id, rd_data_v, frame_done} !== 5'b0 || rd_data !== '0) begin
      errors++;
      $display("FAIL reset_mid: got %b/%h expected 0/0",
               {halt, rd_bank_v, rd_bank_id, rd_data_v, frame_done}, rd_data[15:0]);
    end
    fd_seen = 0;
    pulse_start();
    run_frame(16'h1234, FV);
    checks++;
    if (fd_seen != 1) begin
      errors++;
      $display("FAIL frame_done_after_reset: got %0d expected 1", fd_seen);
    end
  endtask

  task automatic test_idle_ops();
    clr(); rd_release = 1'b1;
    step();
    clr(); rd_en = 1'b1; rd_addr = 7'd5;
    step();
    clr();
    checks++;
    if (rd_data_v !== 1'b0 || rd_bank_id !== 1'b0 || rd_bank_v !== 1'b0) begin
      errors++;
      $display("FAIL idle_ops: got %b%b%b expected 000", rd_data_v, rd_bank_id, rd_bank_v);
    end
    pulse_start();
    feed(10, 7);
    pulse_start();
    feed(BD - 10, 7);
    checks++;
    if (rd_bank_v !== 1'b1) begin
      errors++;
      $display("FAIL start_mid_fill: got rd_bank_v %b expected 1", rd_bank_v);
    end
    fd_seen = 0;
    run_frame(7, FV);
    checks++;
    if (fd_seen != 1) begin
      errors++;
      $display("FAIL frame_done_idle_ops: got %0d expected 1", fd_seen);
    end
  endtask

  initial begin
    clr();
    in_fea  = '0;
    rd_addr = '0;
    test_reset();
    test_fill_bank0();
    test_halt();
    test_release();
    test_frame();
    test_reset_mid();
    test_idle_ops();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
